// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a frame of products and drains the result byte-serially, LSB first.
// Optional clamp-on-overflow build: define PRODUCT_ACCUMULATOR_SAT_EN.
module product_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [7:0]        o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_ovf,
    output logic              o_busy
);

    localparam int NB    = ACC_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_rem;
    logic [IDX_W-1:0]  r_idx;
    logic              r_ovf;

    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic [ACC_W-1:0]  w_shift;
    logic              w_last;

    assign w_sum   = {1'b0, r_acc} + {1'b0, ACC_W'(i_in_data)};
    assign w_carry = w_sum[ACC_W];
    assign w_shift = r_acc >> {r_idx, 3'b000};
    assign w_last  = (r_idx == LAST_IDX);

    // Every output is decoded from registered state only.
    assign o_in_ready  = (r_state == ACCUM);
    assign o_out_valid = (r_state == DRAIN);
    assign o_out_data  = (r_state == DRAIN) ? w_shift[7:0] : 8'h00;
    assign o_out_last  = (r_state == DRAIN) && w_last;
    assign o_ovf       = r_ovf;
    assign o_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (i_len != '0) ? ACCUM : DRAIN;
                end
            end
            ACCUM: begin
                if (i_in_valid && (r_rem == CNT_W'(1))) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_out_ready && w_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_idx <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc <= '0;
                        r_rem <= i_len;
                        r_idx <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (i_in_valid) begin
                        r_rem <= r_rem - 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
                        // Once clamped, the sum is frozen for the rest of the frame.
                        if (!r_ovf) begin
                            r_acc <= w_carry ? '1 : w_sum[ACC_W-1:0];
                        end
`else
                        r_acc <= w_sum[ACC_W-1:0];
`endif
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_out_ready) begin
                        r_idx <= w_last ? '0 : r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Streaming accumulator directly downstream of the 8x8 operand multiplier in the Tiny Tapeout top level. It consumes a frame of `len` 16-bit products over a valid/ready handshake and sums them into an ACC_W-bit accumulator. It then drains the sum byte-serially, LSB first, to the 8-bit output pins. One frame is in flight at a time, and the frame is armed by a `start` pulse.

## Interface
- DATA_W, 16, product width; zero-extended into the accumulator
- ACC_W, 16, accumulator width; multiple of 8 and ≥ DATA_W
- CNT_W, 8, width of the frame-length counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  arm a frame; sampled only in IDLE
- len  in  CNT_W  number of products in the frame; latched on accepted `start`
- in_data  in  DATA_W  product sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a sample this cycle
- out_data  out  8  current result byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer takes out_data this cycle
- out_last  out  1  out_data is the final, most significant byte
- ovf  out  1  sticky: the frame sum exceeded 2^ACC_W−1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, DRAIN. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- **IDLE**
  - in_ready=0, out_valid=0.
  - On `start`: acc←0, ovf←0, rem←len, byte index←0.
  - Next state is ACCUM if len≠0; otherwise DRAIN, which emits a zero result.
- **ACCUM**
  - in_ready=1.
  - Each accept (in_valid & in_ready): acc←acc+zext(in_data), rem←rem−1.
  - The accept that takes rem from 1 to 0 moves the block to DRAIN.
  - Cycles with in_valid=0 hold all state.
- **DRAIN**
  - out_valid=1, out_data=acc[8·idx+7 : 8·idx], out_last=(idx==ACC_W/8−1).
  - Each out_ready: idx←idx+1.
  - out_ready while out_last=1 returns the block to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
- **Overflow**: carry out of bit ACC_W−1 sets ovf. The accumulator wraps modulo 2^ACC_W unless saturation is compiled in (see Configuration).
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `len` is only sampled on the accepted `start`.
  - in_valid outside ACCUM is ignored.
- **Reset**: rst_n low in any state, including mid-frame, immediately forces IDLE. acc=0, rem=0, idx=0, ovf=0. The partial frame is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0x00, ovf=0, busy=0.
- `start` at edge N: busy=1 and in_ready=1 from cycle N+1.
- With len=0, out_valid=1 from cycle N+1 and out_data=0x00.
- Throughput: one sample per cycle in ACCUM.
- Last sample accepted at edge K: in_ready=0 and out_valid=1 in cycle K+1. The sum includes that sample.
- Drain takes ACC_W/8 handshakes; with out_ready held high, that is 2 cycles for ACC_W=16.
- The final drain handshake at edge M gives busy=0 in cycle M+1. A new `start` is accepted in that cycle.
- ovf updates in the same edge as the accumulate that overflows. It holds through DRAIN and clears only on the next accepted `start` or on reset.

## Configuration
- Macro: `PRODUCT_ACCUMULATOR_SAT_EN`.
- **Defined**: on overflow, acc clamps to 2^ACC_W−1 and stays clamped for the rest of the frame. Later samples do not change it.
- **Undefined**: acc wraps modulo 2^ACC_W.
- ovf behaves the same in both builds.

## Test plan
- Basic frame: start with len=3, samples 0x0010, 0x0020, 0x0030, out_ready=1 → bytes 0x60 then 0x00; out_last on the second byte; ovf=0; busy drops 1 cycle after the last byte.
- Empty frame: start with len=0 → out_valid=1 in the next cycle with 0x00, 0x00, and no input is accepted.
- Overflow: len=2, samples 0xFFFF then 0x0002.
  - Without the macro → bytes 0x01, 0x00, ovf=1.
  - With the macro → bytes 0xFF, 0xFF, ovf=1.
- Backpressure and bubbles:
  - in_valid toggles every other cycle, len=4, samples 0x0001 each → sum 0x0004.
  - out_ready low for 3 cycles in DRAIN → out_data is held at 0x04 and out_valid stays 1.
- Ignored start: pulse start with len=9 mid-ACCUM of a len=2 frame → the frame still ends after 2 samples.
- Mid-frame reset: assert rst_n=0 after 1 of 3 samples → all outputs at reset values. A following len=1 frame with sample 0x1234 → 0x34, 0x12.
